packet_buffer_read_arbiter: RTL and testbench

Round-robin arbiter that shares the single read port of `packet_buffer_ram_driver` among `N_REQ` requesters, such as the UART dump engine and the frame parser. Each requester uses the same req/addr → ready/out handshake it would use on the RAM driver directly. The arbiter serialises transactions and routes each `read_ready` pulse back to the owner. It supports optional burst locking and a watchdog that frees the port if the RAM never answers.

---
 rtl/packet_buffer_read_arbiter_pkg.sv | 12 +
 rtl/packet_buffer_read_arbiter_if.sv | 31 +++
 rtl/packet_buffer_read_arbiter_rr_pick.sv | 42 ++++
 rtl/packet_buffer_read_arbiter.sv | 171 +++++++++++++++++
 tb/tb_packet_buffer_read_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/packet_buffer_read_arbiter_pkg.sv
// rtl/packet_buffer_read_arbiter_pkg.sv - shared constants and helpers for the packet buffer read arbiter
package packet_buffer_read_arbiter_pkg;

    localparam int BYTE_LEN           = 8;
    localparam int PACKET_BUFFER_SIZE = 2048;

    // Width of a counter that must hold values 0..max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/packet_buffer_read_arbiter_if.sv
// rtl/packet_buffer_read_arbiter_if.sv - requester and RAM-driver signal bundle for the read arbiter
interface packet_buffer_read_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 11
);
    import packet_buffer_read_arbiter_pkg::*;

    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        lock;
    logic [N_REQ*ADDR_W-1:0] addr;
    logic [N_REQ-1:0]        ready;
    logic [BYTE_LEN-1:0]     read_out;
    logic [N_REQ-1:0]        grant;
    logic                    timeout_err;

    logic                    ram_read_req;
    logic [ADDR_W-1:0]       ram_read_addr;
    logic                    ram_read_ready;
    logic [BYTE_LEN-1:0]     ram_read_out;

    modport master (
        input  req, lock, addr, ram_read_ready, ram_read_out,
        output ready, read_out, grant, timeout_err, ram_read_req, ram_read_addr
    );

    modport slave (
        output req, lock, addr, ram_read_ready, ram_read_out,
        input  ready, read_out, grant, timeout_err, ram_read_req, ram_read_addr
    );

endinterface

// File: rtl/packet_buffer_read_arbiter_rr_pick.sv
// rtl/packet_buffer_read_arbiter_rr_pick.sv - combinational round-robin picker starting after the last winner
module packet_buffer_read_arbiter_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // Each requester's distance from last+1 (mod N); the nearest requesting one wins.
    always_comb begin
        int best_d;
        int d;
        best_d  = N;
        d       = 0;
        o_idx   = '0;
        o_valid = |i_req;
        for (int i = 0; i < N; i++) begin
            if (i_req[i]) begin
                d = i - int'(i_last) - 1;
                if (d < 0) begin
                    d = d + N;
                end
                if (d < best_d) begin
                    best_d = d;
                    o_idx  = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < N; i++) begin
            o_onehot[i] = o_valid && (o_idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/packet_buffer_read_arbiter.sv
// rtl/packet_buffer_read_arbiter.sv - round-robin sharing of the packet buffer read port with burst lock and watchdog
module packet_buffer_read_arbiter
    import packet_buffer_read_arbiter_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int RAM_SIZE  = PACKET_BUFFER_SIZE,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                         clk,
    input  logic                         reset_n,
    packet_buffer_read_arbiter_if.master bus
);

    localparam int ADDR_W  = $clog2(RAM_SIZE);
    localparam int IDX_W   = $clog2(N_REQ);
    localparam int BURST_W = cnt_w(MAX_BURST);
    localparam int TO_W    = cnt_w(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t             r_state;
    logic [N_REQ-1:0]   r_grant;
    logic [IDX_W-1:0]   r_gidx;
    logic [IDX_W-1:0]   r_last;
    logic               r_ram_req;
    logic [ADDR_W-1:0]  r_ram_addr;
    logic [BURST_W-1:0] r_burst;
    logic [TO_W-1:0]    r_tcnt;
    logic               r_timeout_err;

    state_t             w_state;
    logic [N_REQ-1:0]   w_grant;
    logic [IDX_W-1:0]   w_gidx;
    logic [IDX_W-1:0]   w_last;
    logic               w_ram_req;
    logic [ADDR_W-1:0]  w_ram_addr;
    logic [BURST_W-1:0] w_burst;
    logic [TO_W-1:0]    w_tcnt;
    logic               w_timeout_err;

    logic [N_REQ-1:0]   w_pick_onehot;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_valid;
    logic [ADDR_W-1:0]  w_addr [N_REQ];
    logic               w_req_g;
    logic               w_lock_g;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_addr
        assign w_addr[gi] = bus.addr[gi*ADDR_W +: ADDR_W];
    end

    assign w_req_g  = bus.req[r_gidx];
    assign w_lock_g = bus.lock[r_gidx];

    packet_buffer_read_arbiter_rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req    (bus.req),
        .i_last   (r_last),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_gidx        <= '0;
            r_last        <= IDX_W'(N_REQ - 1);
            r_ram_req     <= 1'b0;
            r_ram_addr    <= '0;
            r_burst       <= '0;
            r_tcnt        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_grant       <= w_grant;
            r_gidx        <= w_gidx;
            r_last        <= w_last;
            r_ram_req     <= w_ram_req;
            r_ram_addr    <= w_ram_addr;
            r_burst       <= w_burst;
            r_tcnt        <= w_tcnt;
            r_timeout_err <= w_timeout_err;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_grant       = r_grant;
        w_gidx        = r_gidx;
        w_last        = r_last;
        w_ram_req     = r_ram_req;
        w_ram_addr    = r_ram_addr;
        w_burst       = r_burst;
        w_tcnt        = r_tcnt;
        w_timeout_err = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_grant    = w_pick_onehot;
                    w_gidx     = w_pick_idx;
                    w_ram_addr = w_addr[w_pick_idx];
                    w_ram_req  = 1'b1;
                    w_burst    = '0;
                    w_tcnt     = '0;
                    w_state    = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // A completion on the watchdog's final cycle still counts as success.
                if (bus.ram_read_ready) begin
                    w_ram_req = 1'b0;
                    if (w_lock_g && (r_burst < BURST_W'(MAX_BURST - 1))) begin
                        w_burst = r_burst + BURST_W'(1);
                        w_state = ST_HOLD;
                    end else begin
                        w_last  = r_gidx;
                        w_grant = '0;
                        w_state = ST_IDLE;
                    end
                end else if (r_tcnt == TO_W'(TIMEOUT - 1)) begin
                    w_timeout_err = 1'b1;
                    w_ram_req     = 1'b0;
                    w_last        = r_gidx;
                    w_grant       = '0;
                    w_state       = ST_IDLE;
                end else begin
                    w_tcnt = r_tcnt + TO_W'(1);
                end
            end

            ST_HOLD: begin
                if (w_req_g) begin
                    w_ram_addr = w_addr[r_gidx];
                    w_ram_req  = 1'b1;
                    w_tcnt     = '0;
                    w_state    = ST_WAIT;
                end else if (!w_lock_g) begin
                    w_last  = r_gidx;
                    w_grant = '0;
                    w_state = ST_IDLE;
                end
            end

            default: begin
                w_grant   = '0;
                w_ram_req = 1'b0;
                w_state   = ST_IDLE;
            end
        endcase
    end

    // Late data after an abort finds the port in IDLE with no owner, so it is dropped.
    assign bus.ready         = (r_state == ST_WAIT) ? (r_grant & {N_REQ{bus.ram_read_ready}}) : '0;
    assign bus.read_out      = bus.ram_read_out;
    assign bus.grant         = r_grant;
    assign bus.timeout_err   = r_timeout_err;
    assign bus.ram_read_req  = r_ram_req;
    assign bus.ram_read_addr = r_ram_addr;

endmodule

// File: tb/tb_packet_buffer_read_arbiter.sv
// tb/tb_packet_buffer_read_arbiter.sv - scoreboard bench for the packet buffer read arbiter
module tb_packet_buffer_read_arbiter;

    localparam int N_REQ    = 2;
    localparam int RAM_SIZE = 2048;
    localparam int ADDR_W   = $clog2(RAM_SIZE);
    localparam int LAT      = 2;

    typedef struct packed {
        logic [N_REQ-1:0]  grant;
        logic [ADDR_W-1:0] addr;
    } iss_t;

    typedef struct packed {
        logic [N_REQ-1:0] rdy;
        logic [7:0]       data;
    } rd_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    packet_buffer_read_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W)) bus();

    packet_buffer_read_arbiter #(
        .N_REQ     (N_REQ),
        .RAM_SIZE  (RAM_SIZE),
        .MAX_BURST (4),
        .TIMEOUT   (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    iss_t iss_q[$];
    rd_t  rd_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   rd_seen = 0;

    logic       drv_en   = 1'b1;
    logic       inj      = 1'b0;
    logic [7:0] inj_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_iss(input logic [N_REQ-1:0] g, input logic [ADDR_W-1:0] a);
        iss_t e;
        e.grant = g;
        e.addr  = a;
        iss_q.push_back(e);
    endtask

    task automatic push_rd(input logic [N_REQ-1:0] r, input logic [7:0] d);
        rd_t e;
        e.rdy  = r;
        e.data = d;
        rd_q.push_back(e);
    endtask

    task automatic set_addr(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        bus.addr = {a1, a0};
    endtask

    task automatic do_reset;
        reset_n  = 1'b0;
        bus.req  = '0;
        bus.lock = '0;
        bus.addr = '0;
        drv_en   = 1'b1;
        inj      = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
    endtask

    task automatic wait_issue(output int lat);
        int k;
        k = 0;
        do begin
            cyc(1);
            k++;
        end while (!bus.ram_read_req && k < 50);
        lat = k;
        if (!bus.ram_read_req) begin
            checks++;
            errors++;
            $display("FAIL issue_wait actual=none required=ram_read_req");
        end
    endtask

    task automatic wait_rd(input int n, input string name);
        int target;
        int k;
        target = rd_seen + n;
        k = 0;
        while (rd_seen < target && k < 300) begin
            cyc(1);
            k++;
        end
        chk(name, rd_seen, target);
    endtask

    // RAM driver stand-in: answers LAT cycles after seeing a request, data derived from the live address.
    initial begin
        int  cnt;
        logic pend;
        cnt  = 0;
        pend = 1'b0;
        bus.ram_read_ready = 1'b0;
        bus.ram_read_out   = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            bus.ram_read_ready = 1'b0;
            if (!reset_n) begin
                pend = 1'b0;
            end else if (inj) begin
                bus.ram_read_ready = 1'b1;
                bus.ram_read_out   = inj_data;
                inj                = 1'b0;
            end else if (pend) begin
                if (cnt == LAT) begin
                    bus.ram_read_ready = 1'b1;
                    bus.ram_read_out   = bus.ram_read_addr[7:0] ^ 8'h5A;
                    pend               = 1'b0;
                end else begin
                    cnt++;
                end
            end else if (drv_en && bus.ram_read_req) begin
                pend = 1'b1;
                cnt  = 1;
            end
        end
    end

    initial begin
        logic prev_req;
        iss_t ei;
        rd_t  er;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.ram_read_req && !prev_req) begin
                if (iss_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL issue_unexpected actual=grant %0h addr %0h required=none", bus.grant, bus.ram_read_addr);
                end else begin
                    ei = iss_q.pop_front();
                    chk("issue_grant", bus.grant, ei.grant);
                    chk("issue_addr", bus.ram_read_addr, ei.addr);
                end
            end
            prev_req = bus.ram_read_req;
            if (|bus.ready) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ready_unexpected actual=%0h required=none", bus.ready);
                end else begin
                    er = rd_q.pop_front();
                    chk("ready_vec", bus.ready, er.rdy);
                    chk("read_out", bus.read_out, er.data);
                end
                rd_seen++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int lat;
        int k;
        int errs;

        // Reset state
        do_reset();
        chk("rst_grant", bus.grant, 0);
        chk("rst_ram_req", bus.ram_read_req, 0);
        chk("rst_ram_addr", bus.ram_read_addr, 0);
        chk("rst_timeout_err", bus.timeout_err, 0);
        chk("rst_ready", bus.ready, 0);

        // Single requester; addr changes and req drops after issue
        set_addr(11'h010, 11'h000);
        push_iss(2'b01, 11'h010);
        push_rd(2'b01, 8'h4A);
        bus.req = 2'b01;
        wait_issue(lat);
        chk("issue_latency", lat, 1);
        set_addr(11'h3FF, 11'h000);
        bus.req = 2'b00;
        wait_rd(1, "single_done");
        chk("single_grant_released", bus.grant, 0);
        cyc(3);

        // Contention, no lock: 0,1,0,1,0,1
        do_reset();
        set_addr(11'h020, 11'h131);
        for (int i = 0; i < 3; i++) begin
            push_iss(2'b01, 11'h020);
            push_rd(2'b01, 8'h7A);
            push_iss(2'b10, 11'h131);
            push_rd(2'b10, 8'h6B);
        end
        bus.req = 2'b11;
        wait_rd(6, "contention_done");
        bus.req = 2'b00;
        cyc(4);

        // Burst lock on requester 1, MAX_BURST=4
        do_reset();
        set_addr(11'h003, 11'h0F0);
        for (int i = 0; i < 4; i++) begin
            push_iss(2'b10, 11'h0F0);
            push_rd(2'b10, 8'hAA);
        end
        push_iss(2'b01, 11'h003);
        push_rd(2'b01, 8'h59);
        bus.lock = 2'b10;
        bus.req  = 2'b10;
        wait_issue(lat);
        bus.req = 2'b11;
        wait_rd(4, "burst_done");
        bus.req  = 2'b01;
        bus.lock = 2'b00;
        wait_rd(1, "burst_after");
        bus.req = 2'b00;
        cyc(4);

        // Watchdog with a silent driver
        do_reset();
        drv_en = 1'b0;
        set_addr(11'h010, 11'h055);
        push_iss(2'b01, 11'h010);
        bus.req = 2'b01;
        wait_issue(lat);
        bus.req = 2'b00;
        k = 0;
        do begin
            cyc(1);
            k++;
        end while (!bus.timeout_err && k < 30);
        chk("timeout_cycles", k, 8);
        chk("timeout_grant", bus.grant, 0);
        chk("timeout_ram_req", bus.ram_read_req, 0);
        cyc(1);
        chk("timeout_pulse_width", bus.timeout_err, 0);

        // Late data after the abort
        inj_data = 8'hEE;
        inj      = 1'b1;
        @(negedge clk);
        chk("late_ready", bus.ready, 0);
        cyc(2);

        // Completion on the watchdog's final cycle
        push_iss(2'b10, 11'h055);
        push_rd(2'b10, 8'h3C);
        bus.req = 2'b10;
        wait_issue(lat);
        bus.req = 2'b00;
        cyc(7);
        inj_data = 8'h3C;
        inj      = 1'b1;
        errs = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (bus.timeout_err) errs++;
        end
        chk("ready_wins_timeout", errs, 0);
        chk("ready_wins_grant", bus.grant, 0);

        // Reset during WAIT
        do_reset();
        set_addr(11'h010, 11'h131);
        push_iss(2'b01, 11'h010);
        bus.req = 2'b01;
        wait_issue(lat);
        cyc(1);
        reset_n = 1'b0;
        #1;
        chk("midrst_ram_req", bus.ram_read_req, 0);
        chk("midrst_grant", bus.grant, 0);
        chk("midrst_ready", bus.ready, 0);
        cyc(1);
        push_iss(2'b01, 11'h010);
        push_rd(2'b01, 8'h4A);
        push_iss(2'b10, 11'h131);
        push_rd(2'b10, 8'h6B);
        bus.req = 2'b11;
        reset_n = 1'b1;
        wait_rd(2, "post_reset_done");
        bus.req = 2'b00;
        cyc(4);

        chk("issue_q_drained", iss_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
